// File: rtl/grid_io_cfg_bank.sv
// grid_io_cfg_bank: perimeter IO tile with per-pad sync/bypass, output register and polarity, loaded by a serial config chain (optional loopback under GRID_IO_CFG_BANK_LOOPBACK_EN)
module grid_io_cfg_bank #(
  parameter int NUM_IN = 14,
  parameter int NUM_OUT = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IN-1:0]  gfpga_pad_GPIN_PAD,
  output logic [NUM_OUT-1:0] gfpga_pad_GPOUT_PAD,
  output logic [NUM_IN-1:0]  inpad,
  input  logic [NUM_OUT-1:0] outpad,
  input  logic               ccff_head,
  input  logic               ccff_shift,
  output logic               ccff_tail,
`ifdef GRID_IO_CFG_BANK_LOOPBACK_EN
  input  logic               io_loopback,
`endif
  output logic               cfg_valid
);
  localparam int CHAIN_LEN = NUM_IN + 2 * NUM_OUT;
  localparam int CW = $clog2(CHAIN_LEN + 1);
  logic [CHAIN_LEN-1:0] chain;
  logic [CW-1:0] count, count_nxt;
  logic [SYNC_STAGES-1:0][NUM_IN-1:0] sync;
  logic [NUM_IN-1:0] in_sync, raw_in, base_in;
  logic [NUM_OUT-1:0] out_reg, out_inv, v, oreg, drive;
  assign in_sync = chain[NUM_IN-1:0];
  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out_cfg
    assign out_reg[j] = chain[NUM_IN+2*j];
    assign out_inv[j] = chain[NUM_IN+2*j+1];
  end
  // a shift while a full configuration is held starts a fresh load
  assign count_nxt = (count == CW'(CHAIN_LEN)) ? CW'(1) : count + CW'(1);
  // configuration chain, load counter and registered valid flag
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      chain <= '0;
      count <= '0;
      cfg_valid <= 1'b0;
    end else if (ccff_shift) begin
      chain <= {chain[CHAIN_LEN-2:0], ccff_head};
      count <= count_nxt;
      cfg_valid <= (count_nxt == CW'(CHAIN_LEN));
    end
  // free-running synchronizers and output registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync <= '0;
      oreg <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], gfpga_pad_GPIN_PAD};
      oreg <= v;
    end
  assign ccff_tail = chain[CHAIN_LEN-1];
  assign v = outpad ^ out_inv;
  assign drive = (out_reg & oreg) | (~out_reg & v);
  assign base_in = (in_sync & sync[SYNC_STAGES-1]) | (~in_sync & gfpga_pad_GPIN_PAD);
`ifdef GRID_IO_CFG_BANK_LOOPBACK_EN
  logic [NUM_IN-1:0] lb_in;
  for (genvar i = 0; i < NUM_IN; i++) begin : g_lb
    if (i < NUM_OUT) begin : g_map
      assign lb_in[i] = drive[i];
    end else begin : g_zero
      assign lb_in[i] = 1'b0;
    end
  end
  assign raw_in = io_loopback ? lb_in : base_in;
`else
  assign raw_in = base_in;
`endif
  assign inpad = cfg_valid ? raw_in : '0;
  assign gfpga_pad_GPOUT_PAD = cfg_valid ? drive : '0;
endmodule

// File: tb/tb_grid_io_cfg_bank.sv
// tb_grid_io_cfg_bank: directed self-checking bench for grid_io_cfg_bank at default parameters
module tb_grid_io_cfg_bank;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [13:0] gpin = '0;
  logic [6:0] gpout;
  logic [13:0] inpad;
  logic [6:0] outpad = '0;
  logic ccff_head = 1'b0, ccff_shift = 1'b0, ccff_tail, cfg_valid;
`ifdef GRID_IO_CFG_BANK_LOOPBACK_EN
  logic io_loopback = 1'b0;
`endif
  int n_checks = 0, n_fail = 0;
  logic [27:0] cfg1, cfg2;
  logic [3:0] pat;
  always #5 clk = ~clk;
  grid_io_cfg_bank dut (
    .clk(clk),
    .reset(reset),
    .gfpga_pad_GPIN_PAD(gpin),
    .gfpga_pad_GPOUT_PAD(gpout),
    .inpad(inpad),
    .outpad(outpad),
    .ccff_head(ccff_head),
    .ccff_shift(ccff_shift),
    .ccff_tail(ccff_tail),
`ifdef GRID_IO_CFG_BANK_LOOPBACK_EN
    .io_loopback(io_loopback),
`endif
    .cfg_valid(cfg_valid)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic shift(input logic b);
    ccff_head = b;
    ccff_shift = 1'b1;
    tick();
    ccff_shift = 1'b0;
  endtask
  task automatic load27(input logic [27:0] c);
    for (int k = 0; k < 27; k++) shift(c[27-k]);
  endtask
  initial begin
    cfg1 = {14'h1555, 14'h3fff};
    cfg2 = cfg1;
    cfg2[0] = 1'b0;
    cfg2[18] = 1'b0;
    cfg2[19] = 1'b1;
    pat = 4'b1011;
    gpin = 14'($urandom);
    outpad = 7'($urandom);
    ccff_head = 1'b1;
    ccff_shift = 1'b1;
    tick(3);
    check("rst_inpad", 32'(inpad), 0);
    check("rst_gpout", 32'(gpout), 0);
    check("rst_tail", 32'(ccff_tail), 0);
    check("rst_valid", 32'(cfg_valid), 0);
    ccff_shift = 1'b0;
    ccff_head = 1'b0;
    gpin = '0;
    outpad = '0;
    reset = 1'b0;
    tick(4);
    load27(cfg1);
    check("load27_valid", 32'(cfg_valid), 0);
    shift(cfg1[0]);
    check("load28_valid", 32'(cfg_valid), 1);
    check("idle_inpad", 32'(inpad), 0);
    gpin[3] = 1'b1;
    #1 check("sync_c0", 32'(inpad[3]), 0);
    tick();
    check("sync_c1", 32'(inpad[3]), 0);
    tick();
    check("sync_c2", 32'(inpad[3]), 1);
    outpad[5] = 1'b1;
    #1 check("oreg_c0", 32'(gpout[5]), 0);
    tick();
    check("oreg_c1", 32'(gpout[5]), 1);
    load27(cfg2);
    shift(cfg2[0]);
    check("cfg2_valid", 32'(cfg_valid), 1);
    gpin[0] = 1'b1;
    #1 check("byp_hi", 32'(inpad[0]), 1);
    gpin[0] = 1'b0;
    #1 check("byp_lo", 32'(inpad[0]), 0);
    outpad[2] = 1'b1;
    #1 check("inv_hi", 32'(gpout[2]), 0);
    outpad[2] = 1'b0;
    #1 check("inv_lo", 32'(gpout[2]), 1);
    for (int k = 0; k < 28; k++) begin
      if (k < 4) check($sformatf("tail_old%0d", k), 32'(ccff_tail), 32'(cfg2[27-k]));
      shift(cfg1[27-k]);
      if (k == 0) check("restart_valid", 32'(cfg_valid), 0);
      if (k == 26) check("relaod27_valid", 32'(cfg_valid), 0);
    end
    check("reload28_valid", 32'(cfg_valid), 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("tail_new%0d", k), 32'(ccff_tail), 32'(cfg1[27-k]));
      shift(pat[3-k]);
      if (k == 0) check("extra_valid", 32'(cfg_valid), 0);
    end
    for (int k = 0; k < 10; k++) shift(1'b1);
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 check("midrst_valid", 32'(cfg_valid), 0);
    check("midrst_tail", 32'(ccff_tail), 0);
    tick();
    load27(cfg1);
    check("post_rst27_valid", 32'(cfg_valid), 0);
    shift(cfg1[0]);
    check("post_rst28_valid", 32'(cfg_valid), 1);
`ifdef GRID_IO_CFG_BANK_LOOPBACK_EN
    gpin[10] = 1'b1;
    outpad[1] = 1'b1;
    io_loopback = 1'b1;
    #1 check("lb_c0", 32'(inpad[1]), 0);
    tick();
    check("lb_c1", 32'(inpad[1]), 1);
    check("lb_hi_zero", 32'(inpad[10]), 0);
    check("lb_pad", 32'(gpout[1]), 1);
    io_loopback = 1'b0;
    outpad[1] = 1'b0;
    gpin[10] = 1'b0;
    tick(3);
`endif
    tick(2);
    check("pre_arst_inpad", 32'(inpad[3]), 1);
    check("pre_arst_gpout", 32'(gpout[5]), 1);
    #2 reset = 1'b1;
    #1 check("arst_inpad", 32'(inpad), 0);
    check("arst_gpout", 32'(gpout), 0);
    check("arst_valid", 32'(cfg_valid), 0);
    reset = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
